// File: rtl/xgmac_ipif_pkg.sv
// Shared types and constants for the IPIF register-access sequencer.
// Optional read-compare feature is enabled with the XGMAC_IPIF_RDCHK_EN macro.
package xgmac_ipif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } ipif_state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int TMR_W  = 16;

    // Increment v by one when en is set, holding at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Masked read-compare: 1 when any masked bit differs from the expected value.
    function automatic logic rd_mismatch(input logic [DATA_W-1:0] rdata,
                                         input logic [DATA_W-1:0] exp_v,
                                         input logic [DATA_W-1:0] mask);
        return (((rdata ^ exp_v) & mask) != {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/xgmac_ipif_fifo.sv
// Synchronous operation queue for the IPIF sequencer. The head entry is
// presented combinationally on rdata; push/pop are ignored when full/empty.
// Entry width depends on XGMAC_IPIF_RDCHK_EN in the instantiating top.
module xgmac_ipif_fifo
    import xgmac_ipif_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/xgmac_ipif_seq.sv
// IPIF register-access sequencer: queues operations, issues them one at a time
// with chip-select decode and ack timeout, returns responses and keeps counters.
// Define XGMAC_IPIF_RDCHK_EN to enable masked read-compare (rsp_mismatch/mismatch_cnt).
module xgmac_ipif_seq
    import xgmac_ipif_pkg::*;
#(
    parameter int C_NUM_CS     = 1,
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_TIMEOUT    = 255,
    localparam int CS_W        = (C_NUM_CS > 1) ? $clog2(C_NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                resetdone,
    output logic                rx_axis_aresetn,
    output logic                tx_axis_aresetn,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_rnw,
    input  logic [CS_W-1:0]     op_cs,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic [DATA_W-1:0]   op_exp,
    input  logic [DATA_W-1:0]   op_mask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                rsp_mismatch,
    output logic                bus2ip_clk,
    output logic                bus2ip_reset,
    output logic [C_NUM_CS-1:0] bus2ip_cs,
    output logic                bus2ip_rnw,
    output logic [ADDR_W-1:0]   bus2ip_addr,
    output logic [DATA_W-1:0]   bus2ip_data,
    input  logic [DATA_W-1:0]   ip2bus_data,
    input  logic                ip2bus_rdack,
    input  logic                ip2bus_wrack,
    input  logic                ip2bus_error,
    output logic [CNT_W-1:0]    op_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    mismatch_cnt
);

`ifdef XGMAC_IPIF_RDCHK_EN
    localparam int OP_W = 1 + CS_W + ADDR_W + 3 * DATA_W;
`else
    localparam int OP_W = 1 + CS_W + ADDR_W + DATA_W;
`endif
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(C_TIMEOUT - 1);

    // Queue interface and head-entry fields.
    logic [OP_W-1:0]     fifo_wdata_s;
    logic [OP_W-1:0]     fifo_rdata_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    logic                head_rnw_s;
    logic [CS_W-1:0]     head_cs_s;
    logic [ADDR_W-1:0]   head_addr_s;
    logic [DATA_W-1:0]   head_wdata_s;
    logic [C_NUM_CS-1:0] cs_dec_s;
    logic                ack_s;
    logic                handshake_s;

    // Registered state and outputs.
    ipif_state_e         state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                run_q, run_d;
    logic                axis_rst_q, axis_rst_d;
    logic [C_NUM_CS-1:0] cs_q, cs_d;
    logic                rnw_q, rnw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]    op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

`ifdef XGMAC_IPIF_RDCHK_EN
    logic [DATA_W-1:0]   head_exp_s;
    logic [DATA_W-1:0]   head_mask_s;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic                rsp_mm_q, rsp_mm_d;
    logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d;

    assign fifo_wdata_s = {op_rnw, op_cs, op_addr, op_wdata, op_exp, op_mask};
    assign {head_rnw_s, head_cs_s, head_addr_s, head_wdata_s, head_exp_s, head_mask_s} = fifo_rdata_s;
    assign rsp_mismatch = rsp_mm_q;
    assign mismatch_cnt = mm_cnt_q;
`else
    logic unused_rdchk_s;

    assign fifo_wdata_s   = {op_rnw, op_cs, op_addr, op_wdata};
    assign {head_rnw_s, head_cs_s, head_addr_s, head_wdata_s} = fifo_rdata_s;
    assign unused_rdchk_s = ^{op_exp, op_mask};
    assign rsp_mismatch   = 1'b0;
    assign mismatch_cnt   = {CNT_W{1'b0}};
`endif

    assign op_ready     = run_q & ~fifo_full_s;
    assign push_s       = op_valid & op_ready;
    assign ack_s        = rnw_q ? ip2bus_rdack : ip2bus_wrack;
    assign handshake_s  = rsp_valid_q & rsp_ready;

    assign bus2ip_clk      = clk;
    assign bus2ip_reset    = ~rst_n;
    assign bus2ip_cs       = cs_q;
    assign bus2ip_rnw      = rnw_q;
    assign bus2ip_addr     = addr_q;
    assign bus2ip_data     = wdata_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign op_cnt          = op_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign rx_axis_aresetn = axis_rst_q;
    assign tx_axis_aresetn = axis_rst_q;

    xgmac_ipif_fifo #(
        .DW    (OP_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .rdata (fifo_rdata_s)
    );

    // One-hot chip-select decode of the head entry; out-of-range indices select nothing.
    always_comb begin
        cs_dec_s = '0;
        for (int i = 0; i < C_NUM_CS; i++) begin
            cs_dec_s[i] = (head_cs_s == CS_W'(i));
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cs_d          = cs_q;
        rnw_d         = rnw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        pop_s         = 1'b0;
`ifdef XGMAC_IPIF_RDCHK_EN
        exp_d         = exp_q;
        mask_d        = mask_q;
        rsp_mm_d      = rsp_mm_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && resetdone) begin
                    pop_s   = 1'b1;
                    cs_d    = cs_dec_s;
                    rnw_d   = head_rnw_s;
                    addr_d  = head_addr_s;
                    wdata_d = head_wdata_s;
                    timer_d = '0;
`ifdef XGMAC_IPIF_RDCHK_EN
                    exp_d   = head_exp_s;
                    mask_d  = head_mask_s;
`endif
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ack_s) begin
                    // An ack wins over a coincident timer expiry.
                    rsp_rdata_d   = rnw_q ? ip2bus_data : {DATA_W{1'b0}};
                    rsp_err_d     = ip2bus_error;
                    rsp_timeout_d = 1'b0;
`ifdef XGMAC_IPIF_RDCHK_EN
                    rsp_mm_d      = rnw_q & rd_mismatch(ip2bus_data, exp_q, mask_q);
`endif
                    cs_d          = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    // Timed-out reads compare as if zero data were returned.
                    rsp_rdata_d   = {DATA_W{1'b0}};
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
`ifdef XGMAC_IPIF_RDCHK_EN
                    rsp_mm_d      = rnw_q & rd_mismatch({DATA_W{1'b0}}, exp_q, mask_q);
`endif
                    cs_d          = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                cs_d        = '0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Saturating counters updated on each response handshake, plus status flops.
    always_comb begin
        run_d      = 1'b1;
        axis_rst_d = resetdone;
        op_cnt_d   = sat_inc(op_cnt_q, handshake_s);
        err_cnt_d  = sat_inc(err_cnt_q, handshake_s & rsp_err_q);
`ifdef XGMAC_IPIF_RDCHK_EN
        mm_cnt_d   = sat_inc(mm_cnt_q, handshake_s & rsp_mm_q);
`endif
    end

    // State and output registers; reset drops chip select and response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            run_q         <= 1'b0;
            axis_rst_q    <= 1'b0;
            cs_q          <= '0;
            rnw_q         <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            op_cnt_q      <= '0;
            err_cnt_q     <= '0;
`ifdef XGMAC_IPIF_RDCHK_EN
            exp_q         <= '0;
            mask_q        <= '0;
            rsp_mm_q      <= 1'b0;
            mm_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            run_q         <= run_d;
            axis_rst_q    <= axis_rst_d;
            cs_q          <= cs_d;
            rnw_q         <= rnw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            op_cnt_q      <= op_cnt_d;
            err_cnt_q     <= err_cnt_d;
`ifdef XGMAC_IPIF_RDCHK_EN
            exp_q         <= exp_d;
            mask_q        <= mask_d;
            rsp_mm_q      <= rsp_mm_d;
            mm_cnt_q      <= mm_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_xgmac_ipif_seq.sv
// Directed self-checking bench for xgmac_ipif_seq (3 chip selects, depth 4, timeout 8).
// Works with or without XGMAC_IPIF_RDCHK_EN defined.
module tb_xgmac_ipif_seq;

    localparam int NCS = 3;
    localparam int CSW = 2;

    logic            clk;
    logic            rst_n;
    logic            resetdone;
    logic            rx_axis_aresetn, tx_axis_aresetn;
    logic            op_valid, op_ready, op_rnw;
    logic [CSW-1:0]  op_cs;
    logic [31:0]     op_addr, op_wdata, op_exp, op_mask;
    logic            rsp_valid, rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_err, rsp_timeout, rsp_mismatch;
    logic            bus2ip_clk, bus2ip_reset;
    logic [NCS-1:0]  bus2ip_cs;
    logic            bus2ip_rnw;
    logic [31:0]     bus2ip_addr, bus2ip_data;
    logic [31:0]     ip2bus_data;
    logic            ip2bus_rdack, ip2bus_wrack, ip2bus_error;
    logic [15:0]     op_cnt, err_cnt, mismatch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    xgmac_ipif_seq #(
        .C_NUM_CS     (NCS),
        .C_FIFO_DEPTH (4),
        .C_TIMEOUT    (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .resetdone       (resetdone),
        .rx_axis_aresetn (rx_axis_aresetn),
        .tx_axis_aresetn (tx_axis_aresetn),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_rnw          (op_rnw),
        .op_cs           (op_cs),
        .op_addr         (op_addr),
        .op_wdata        (op_wdata),
        .op_exp          (op_exp),
        .op_mask         (op_mask),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .rsp_timeout     (rsp_timeout),
        .rsp_mismatch    (rsp_mismatch),
        .bus2ip_clk      (bus2ip_clk),
        .bus2ip_reset    (bus2ip_reset),
        .bus2ip_cs       (bus2ip_cs),
        .bus2ip_rnw      (bus2ip_rnw),
        .bus2ip_addr     (bus2ip_addr),
        .bus2ip_data     (bus2ip_data),
        .ip2bus_data     (ip2bus_data),
        .ip2bus_rdack    (ip2bus_rdack),
        .ip2bus_wrack    (ip2bus_wrack),
        .ip2bus_error    (ip2bus_error),
        .op_cnt          (op_cnt),
        .err_cnt         (err_cnt),
        .mismatch_cnt    (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Present one operation and hold it until accepted (bounded).
    task automatic push_op(input logic rnw, input logic [CSW-1:0] cs, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] ex, input logic [31:0] mk);
        int guard;
        guard    = 0;
        op_valid = 1'b1; op_rnw = rnw; op_cs = cs;
        op_addr  = addr; op_wdata = wd; op_exp = ex; op_mask = mk;
        while (op_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("push_timeout", 32'd1, 32'd0);
        tick();
        op_valid = 1'b0;
    endtask

    // Wait for chip select, count its high cycles, ack at cycle ack_at (0 = never).
    task automatic do_access(input int ack_at, input logic is_rd, input logic err,
                             input logic [31:0] data, input logic wrong_ack,
                             output int cycles, output logic [NCS-1:0] cs_seen,
                             output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                             output logic rnw_seen);
        int guard;
        guard  = 0;
        cycles = 0;
        while (bus2ip_cs == '0 && guard < 20) begin
            tick();
            guard++;
        end
        cs_seen   = bus2ip_cs;
        addr_seen = bus2ip_addr;
        wd_seen   = bus2ip_data;
        rnw_seen  = bus2ip_rnw;
        while (bus2ip_cs != '0 && cycles < 50) begin
            cycles++;
            ip2bus_rdack = wrong_ack & ~is_rd;
            ip2bus_wrack = wrong_ack & is_rd;
            ip2bus_error = 1'b0;
            if (cycles == ack_at) begin
                ip2bus_data  = data;
                ip2bus_error = err;
                if (is_rd) ip2bus_rdack = 1'b1;
                else       ip2bus_wrack = 1'b1;
            end
            tick();
        end
        ip2bus_rdack = 1'b0;
        ip2bus_wrack = 1'b0;
        ip2bus_error = 1'b0;
        ip2bus_data  = 32'h0000_0000;
    endtask

    task automatic handshake();
        int guard;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("rsp_wait_timeout", 32'd1, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int              cyc;
        logic [NCS-1:0]  cs_seen;
        logic [31:0]     a_seen, d_seen;
        logic            r_seen;

        rst_n = 1'b0; resetdone = 1'b0; op_valid = 1'b0; op_rnw = 1'b0; op_cs = '0;
        op_addr = 32'h0; op_wdata = 32'h0; op_exp = 32'h0; op_mask = 32'h0;
        rsp_ready = 1'b0; ip2bus_data = 32'h0; ip2bus_rdack = 1'b0;
        ip2bus_wrack = 1'b0; ip2bus_error = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_cs",       32'(bus2ip_cs), 32'd0);
        check("rst_rnw",      32'(bus2ip_rnw), 32'd1);
        check("rst_busrst",   32'(bus2ip_reset), 32'd1);
        check("rst_rspv",     32'(rsp_valid), 32'd0);
        check("rst_opready",  32'(op_ready), 32'd0);
        check("rst_axis",     32'({rx_axis_aresetn, tx_axis_aresetn}), 32'd0);
        check("rst_opcnt",    32'(op_cnt), 32'd0);

        rst_n = 1'b1;
        tick();
        check("busrst_low",   32'(bus2ip_reset), 32'd0);
        check("opready_up",   32'(op_ready), 32'd1);
        resetdone = 1'b1;
        check("axis_lag0",    32'(rx_axis_aresetn), 32'd0);
        tick();
        check("axis_lag1",    32'({rx_axis_aresetn, tx_axis_aresetn}), 32'd3);

        // Write with wrack after 3 cycles -> cs high 4 cycles
        push_op(1'b0, 2'd0, 32'h0000_0010, 32'h1234_5678, 32'h0, 32'h0);
        check("wr_lat_n1",    32'(bus2ip_cs), 32'd0);
        tick();
        check("wr_lat_n2",    32'(bus2ip_cs), 32'b001);
        do_access(4, 1'b0, 1'b0, 32'h0, 1'b0, cyc, cs_seen, a_seen, d_seen, r_seen);
        check("wr_cs_cycles", 32'(cyc), 32'd4);
        check("wr_addr",      a_seen, 32'h0000_0010);
        check("wr_data",      d_seen, 32'h1234_5678);
        check("wr_rnw",       32'(r_seen), 32'd0);
        check("wr_rspv",      32'(rsp_valid), 32'd1);
        check("wr_err",       32'(rsp_err), 32'd0);
        handshake();
        check("wr_opcnt",     32'(op_cnt), 32'd1);
        check("wr_rspv_drop", 32'(rsp_valid), 32'd0);

        // Read with rdack + error on CS1
        push_op(1'b1, 2'd1, 32'h0000_0020, 32'h0, 32'h0, 32'h0);
        do_access(2, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, cyc, cs_seen, a_seen, d_seen, r_seen);
        check("rd_cs",        32'(cs_seen), 32'b010);
        check("rd_cycles",    32'(cyc), 32'd2);
        check("rd_rdata",     rsp_rdata, 32'hDEAD_BEEF);
        check("rd_err",       32'(rsp_err), 32'd1);
        check("rd_to",        32'(rsp_timeout), 32'd0);
        handshake();
        check("rd_errcnt",    32'(err_cnt), 32'd1);

        // Read on CS2 with only the wrong ack -> timeout after exactly 8 cycles
        push_op(1'b1, 2'd2, 32'h0000_0040, 32'h0, 32'h0, 32'h0);
        do_access(0, 1'b1, 1'b0, 32'h0, 1'b1, cyc, cs_seen, a_seen, d_seen, r_seen);
        check("to_cs",        32'(cs_seen), 32'b100);
        check("to_cycles",    32'(cyc), 32'd8);
        check("to_flag",      32'(rsp_timeout), 32'd1);
        check("to_err",       32'(rsp_err), 32'd1);
        handshake();
        check("to_opcnt",     32'(op_cnt), 32'd3);
        check("to_errcnt",    32'(err_cnt), 32'd2);

        // Out-of-range chip select: no cs, times out after 8 cycles
        push_op(1'b0, 2'd3, 32'h0000_0050, 32'h5, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("oor_cs",       32'(bus2ip_cs), 32'd0);
        check("oor_rspv_c7",  32'(rsp_valid), 32'd0);
        tick();
        check("oor_rspv_c8",  32'(rsp_valid), 32'd1);
        check("oor_to",       32'(rsp_timeout), 32'd1);
        handshake();
        check("oor_errcnt",   32'(err_cnt), 32'd3);

        // Queue 4 ops while resetdone is low, then drain in order
        resetdone = 1'b0;
        tick();
        check("axis_fall",    32'(tx_axis_aresetn), 32'd0);
        for (int i = 0; i < 4; i++)
            push_op(1'b0, 2'd0, 32'h0000_0100 + 32'(i), 32'h0000_00A0 + 32'(i), 32'h0, 32'h0);
        check("q_full",       32'(op_ready), 32'd0);
        tick(); tick();
        check("q_no_issue",   32'(bus2ip_cs), 32'd0);
        resetdone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_access(1, 1'b0, 1'b0, 32'h0, 1'b0, cyc, cs_seen, a_seen, d_seen, r_seen);
            check("q_addr",   a_seen, 32'h0000_0100 + 32'(i));
            check("q_data",   d_seen, 32'h0000_00A0 + 32'(i));
            handshake();
        end
        check("q_opcnt",      32'(op_cnt), 32'd8);

        // Masked read-compare
        push_op(1'b1, 2'd0, 32'h0000_0030, 32'h0, 32'h0000_00FF, 32'h0000_000F);
        do_access(2, 1'b1, 1'b0, 32'h0000_00F3, 1'b0, cyc, cs_seen, a_seen, d_seen, r_seen);
        check("mm_rdata",     rsp_rdata, 32'h0000_00F3);
`ifdef XGMAC_IPIF_RDCHK_EN
        check("mm_flag",      32'(rsp_mismatch), 32'd1);
        handshake();
        check("mm_cnt",       32'(mismatch_cnt), 32'd1);
`else
        check("mm_flag_off",  32'(rsp_mismatch), 32'd0);
        handshake();
        check("mm_cnt_off",   32'(mismatch_cnt), 32'd0);
`endif
        check("mm_opcnt",     32'(op_cnt), 32'd9);

        // Reset during ACCESS with a second op queued
        push_op(1'b0, 2'd0, 32'h0000_0060, 32'h6, 32'h0, 32'h0);
        push_op(1'b0, 2'd1, 32'h0000_0070, 32'h7, 32'h0, 32'h0);
        check("ar_cs_up",     32'(bus2ip_cs), 32'b001);
        rst_n = 1'b0;
        #1;
        check("ar_cs_drop",   32'(bus2ip_cs), 32'd0);
        check("ar_rspv",      32'(rsp_valid), 32'd0);
        check("ar_opcnt",     32'(op_cnt), 32'd0);
        check("ar_errcnt",    32'(err_cnt), 32'd0);
        check("ar_mmcnt",     32'(mismatch_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("ar_fifo_empty", 32'(bus2ip_cs), 32'd0);
        check("ar_no_rsp",    32'(rsp_valid), 32'd0);
        check("ar_opready",   32'(op_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
